// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the hazard controller and pipeline registers.
// Latency: n/a (declarations only); backpressure: n/a.
package riscv_pipe_pkg;

    localparam int REG_W = 5;

    // addi x0, x0, 0 -- what the pipeline registers load when bubbled or flushed
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    function automatic logic reg_hit(input logic use_rs, input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rd);
        return use_rs && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// ID/EX hazard inputs and stall/flush controls between pipeline datapath and hazard controller.
// Latency: n/a (wiring only); backpressure: n/a.
interface pipeline_hazard_controller_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] rs1_id;
    logic [REG_W-1:0] rs2_id;
    logic             use_rs1_id;
    logic             use_rs2_id;
    logic [REG_W-1:0] rd_ex;
    logic             memread_ex;
    logic             md_op_ex;
    logic             branch_taken_ex;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             flush_id;
    logic             bubble_ex;
    logic             bubble_mem;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex, md_op_ex, branch_taken_ex,
        input  stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem, md_busy, md_done,
               stall_cycles
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex, md_op_ex, branch_taken_ex,
        output stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem, md_busy, md_done,
               stall_cycles
    );
endinterface

// File: rtl/md_sequencer.sv
// Tracks a MUL/DIV op occupying EX and holds the pipeline until its last cycle.
// Latency: stall combinational from md_op_ex; op occupies EX MD_LATENCY cycles; backpressure: none.
module md_sequencer
    import riscv_pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_op_ex,
    output logic md_busy,
    output logic md_stall,
    output logic md_done
);
    localparam int CW = $clog2(MD_LATENCY);

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_busy  = 1'b0;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_op_ex) begin
                    md_busy  = 1'b1;
                    md_stall = 1'b1;
                    state_d  = MD_BUSY;
                    cnt_d    = CW'(MD_LATENCY - 2);
                end
            end
            MD_BUSY: begin
                // md_op_ex is the same instruction still parked in EX, so it is not re-sampled
                md_busy = 1'b1;
                if (cnt_q != '0) begin
                    md_stall = 1'b1;
                    cnt_d    = cnt_q - CW'(1);
                end else begin
                    md_done = 1'b1;
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for load-use, taken-branch redirect and MUL/DIV occupancy; counts stall cycles.
// Latency: controls combinational from inputs/state; backpressure: MUL/DIV > branch > load-use.
module pipeline_hazard_controller #(
    parameter int MD_LATENCY = 4,
    parameter int REG_W      = riscv_pipe_pkg::REG_W,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipeline_hazard_controller_if.slave hz
);
    import riscv_pipe_pkg::*;

    logic             md_busy, md_stall, md_done;
    logic [REG_W-1:0] rd;
    logic             load_use;
    logic             s_if, s_id, s_ex, f_id, b_ex, b_mem;
    logic [CNT_W-1:0] cnt_q;

    md_sequencer #(.MD_LATENCY(MD_LATENCY)) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_op_ex (hz.md_op_ex),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .md_done  (md_done)
    );

    assign rd       = hz.rd_ex;
    assign load_use = hz.memread_ex && (rd != '0) &&
                      (reg_hit(hz.use_rs1_id, hz.rs1_id, rd) || reg_hit(hz.use_rs2_id, hz.rs2_id, rd));

    always_comb begin
        s_if  = 1'b0;
        s_id  = 1'b0;
        s_ex  = 1'b0;
        f_id  = 1'b0;
        b_ex  = 1'b0;
        b_mem = 1'b0;
        if (md_busy) begin
            s_if  = md_stall;
            s_id  = md_stall;
            s_ex  = md_stall;
            b_mem = md_stall;
        end else if (hz.branch_taken_ex) begin
            // the ID instruction is squashed anyway, so a coincident load-use match is moot
            f_id = 1'b1;
            b_ex = 1'b1;
        end else if (load_use) begin
            s_if = 1'b1;
            s_id = 1'b1;
            b_ex = 1'b1;
        end
    end

    // Outputs are forced low while reset is asserted, even if inputs would request a stall
    assign hz.stall_if   = rst_n & s_if;
    assign hz.stall_id   = rst_n & s_id;
    assign hz.stall_ex   = rst_n & s_ex;
    assign hz.flush_id   = rst_n & f_id;
    assign hz.bubble_ex  = rst_n & b_ex;
    assign hz.bubble_mem = rst_n & b_mem;
    assign hz.md_busy    = rst_n & md_busy;
    assign hz.md_done    = rst_n & md_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (s_if && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hz.stall_cycles = cnt_q;

endmodule
